// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register for the 64-bit LEGv8 pipelined datapath.
//
// Purpose:
//   Captures the register-file read data, immediate, register indices and
//   control bits from the ID stage on every clock. It also bypasses the
//   write-back value so that a same-cycle WB write is visible to a read,
//   detects load-use hazards (inserting one bubble), and honours
//   stall/flush requests.
//
// Ports:
//   clk, rst                      rising-edge clock, async active-high reset
//   stall                         hold EX-side state (downstream stall)
//   flush                         next EX slot becomes a bubble
//   id_valid                      ID slot holds a real instruction
//   id_rs1, id_rs2, id_rd         ID register indices
//   id_reg_write, id_mem_read     ID control bits
//   id_imm                        sign-extended immediate
//   id_read_data1, id_read_data2  register-file read ports
//   wb_reg_write, wb_rd, wb_data  WB-stage register write
//   ex_valid                      EX slot valid
//   ex_rs1, ex_rs2, ex_rd         registered indices for EX forwarding
//   ex_reg_write, ex_mem_read     registered control, 0 when ex_valid=0
//   ex_op_a, ex_op_b, ex_imm      registered operands
//   load_use_hazard               combinational; ID must hold this cycle
module id_ex_stage #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_read_data1,
  input  logic [DATA_W-1:0] id_read_data2,
  input  logic              wb_reg_write,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [REG_W-1:0]  ex_rs1,
  output logic [REG_W-1:0]  ex_rs2,
  output logic [REG_W-1:0]  ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic              load_use_hazard
);

  // X31 is hard-wired zero: it is never bypassed and never a hazard source.
  localparam logic [REG_W-1:0] ZERO_REG = '1;

  logic              wbHitA;
  logic              wbHitB;
  logic              wbLive;
  logic [DATA_W-1:0] bypA;
  logic [DATA_W-1:0] bypB;
  logic              bubble;

  // ID side: the register file updates at the edge while reads are
  // combinational, so a same-cycle WB write must be taken from wb_data.
  always_comb begin
    wbLive = wb_reg_write && (wb_rd != ZERO_REG);
    wbHitA = wbLive && (wb_rd == id_rs1);
    wbHitB = wbLive && (wb_rd == id_rs2);
    bypA   = wbHitA ? wb_data : id_read_data1;
    bypB   = wbHitB ? wb_data : id_read_data2;
  end

  assign load_use_hazard = ex_valid && ex_mem_read && (ex_rd != ZERO_REG) &&
                           id_valid && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // Flush beats stall; a hazard bubble only applies when not stalled.
  assign bubble = flush || (!stall && load_use_hazard);

  // ID -> EX register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_op_a      <= '0;
      ex_op_b      <= '0;
      ex_imm       <= '0;
    end else if (bubble) begin
      ex_valid     <= 1'b0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_op_a      <= '0;
      ex_op_b      <= '0;
      ex_imm       <= '0;
    end else if (stall) begin
      // Held operands track WB writes so they are not stale on release.
      if (wbLive && (wb_rd == ex_rs1)) ex_op_a <= wb_data;
      if (wbLive && (wb_rd == ex_rs2)) ex_op_b <= wb_data;
    end else begin
      ex_valid     <= id_valid;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rd        <= id_rd;
      ex_reg_write <= id_reg_write && id_valid;
      ex_mem_read  <= id_mem_read && id_valid;
      ex_op_a      <= bypA;
      ex_op_b      <= bypB;
      ex_imm       <= id_imm;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
// Self-checking bench for id_ex_stage. A behavioural register file lives in
// the bench: operands are expected to equal the architectural register value
// after this cycle's write-back, and the EX slot follows the stall / flush /
// load-use rules. Directed sequences are followed by randomized traffic.
module tb_id_ex_stage;

  localparam int DATA_W = 64;
  localparam int REG_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall, flush, id_valid;
  logic [REG_W-1:0]  id_rs1, id_rs2, id_rd;
  logic              id_reg_write, id_mem_read;
  logic [DATA_W-1:0] id_imm, id_read_data1, id_read_data2;
  logic              wb_reg_write;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              ex_valid;
  logic [REG_W-1:0]  ex_rs1, ex_rs2, ex_rd;
  logic              ex_reg_write, ex_mem_read;
  logic [DATA_W-1:0] ex_op_a, ex_op_b, ex_imm;
  logic              load_use_hazard;

  id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_imm(id_imm),
    .id_read_data1(id_read_data1), .id_read_data2(id_read_data2),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm),
    .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  // Bench register file (entry 31 stays zero) and expected EX slot.
  logic [DATA_W-1:0] rf [32];
  logic              mValid, mRw, mMr;
  logic [REG_W-1:0]  mRs1, mRs2, mRd;
  logic [DATA_W-1:0] mA, mB, mImm;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mValid = 0; mRw = 0; mMr = 0; mRs1 = 0; mRs2 = 0; mRd = 0;
    mA = 0; mB = 0; mImm = 0;
  endtask

  task automatic checkOutputs(input string tag);
    check({tag, ".valid"}, 64'(ex_valid), 64'(mValid));
    check({tag, ".rs1"},   64'(ex_rs1), 64'(mRs1));
    check({tag, ".rs2"},   64'(ex_rs2), 64'(mRs2));
    check({tag, ".rd"},    64'(ex_rd), 64'(mRd));
    check({tag, ".rw"},    64'(ex_reg_write), 64'(mRw));
    check({tag, ".mr"},    64'(ex_mem_read), 64'(mMr));
    check({tag, ".opa"},   ex_op_a, mA);
    check({tag, ".opb"},   ex_op_b, mB);
    check({tag, ".imm"},   ex_imm, mImm);
  endtask

  // One clock: inputs already set (read data comes from rf), check the
  // hazard before the edge, predict the EX slot, check it after the edge.
  task automatic stepCycle(input string tag);
    logic [DATA_W-1:0] rfAfter [32];
    logic expHaz;
    id_read_data1 = rf[id_rs1];
    id_read_data2 = rf[id_rs2];
    @(negedge clk);
    expHaz = mValid && mMr && (mRd != 31) && id_valid &&
             ((mRd == id_rs1) || (mRd == id_rs2));
    check({tag, ".haz"}, 64'(load_use_hazard), 64'(expHaz));
    rfAfter = rf;
    if (wb_reg_write && wb_rd != 31) rfAfter[wb_rd] = wb_data;
    if (flush || (!stall && expHaz)) begin
      modelReset();
    end else if (stall) begin
      if (wb_reg_write && wb_rd != 31 && wb_rd == mRs1) mA = wb_data;
      if (wb_reg_write && wb_rd != 31 && wb_rd == mRs2) mB = wb_data;
    end else begin
      mValid = id_valid; mRs1 = id_rs1; mRs2 = id_rs2; mRd = id_rd;
      mRw = id_reg_write && id_valid; mMr = id_mem_read && id_valid;
      mA = rfAfter[id_rs1]; mB = rfAfter[id_rs2]; mImm = id_imm;
    end
    @(posedge clk);
    rf = rfAfter;
    #1;
    checkOutputs(tag);
  endtask

  task automatic idle();
    stall = 0; flush = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_reg_write = 0; id_mem_read = 0; id_imm = 0; wb_reg_write = 0;
    wb_rd = 0; wb_data = 0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic mr);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_reg_write = 1; id_mem_read = mr; id_imm = 64'h0000_0000_0000_0040;
  endtask

  function automatic logic [4:0] randIdx();
    if ($urandom_range(0, 8) == 8) return 5'd31;
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 0;
    idle();
    rst = 1;
    modelReset();
    #1;
    checkOutputs("rst0");
    check("rst0.haz", 64'(load_use_hazard), 64'd0);
    @(negedge clk);
    rst = 0;

    // Basic load after reset.
    rf[3] = 64'h11;
    issue(5'd3, 5'd0, 5'd4, 1'b0);
    stepCycle("load");
    check("load.opa_const", ex_op_a, 64'h11);
    check("load.valid_const", 64'(ex_valid), 64'd1);

    // Async reset mid-cycle with a valid EX slot.
    #2 rst = 1;
    #1;
    modelReset();
    checkOutputs("arst");
    check("arst.haz", 64'(load_use_hazard), 64'd0);
    @(negedge clk);
    rst = 0;

    // WB bypass on rs1, and X31 never bypassed.
    rf[5] = 64'hAAAA;
    issue(5'd5, 5'd31, 5'd6, 1'b0);
    wb_reg_write = 1; wb_rd = 5'd5; wb_data = 64'h1234;
    stepCycle("byp");
    check("byp.opa_const", ex_op_a, 64'h1234);
    issue(5'd31, 5'd31, 5'd6, 1'b0);
    wb_reg_write = 1; wb_rd = 5'd31; wb_data = 64'h5555;
    stepCycle("byp31");
    check("byp31.opa_const", ex_op_a, 64'h0);
    wb_reg_write = 0;

    // Load-use: load to X7, then consumer of X7 on rs2.
    issue(5'd1, 5'd2, 5'd7, 1'b1);
    stepCycle("lu.load");
    issue(5'd0, 5'd7, 5'd8, 1'b0);
    stepCycle("lu.bubble");
    check("lu.bubble_valid", 64'(ex_valid), 64'd0);
    check("lu.bubble_rw", 64'(ex_reg_write), 64'd0);
    stepCycle("lu.reissue");
    check("lu.reissue_valid", 64'(ex_valid), 64'd1);

    // Load to X31 is not a hazard.
    issue(5'd1, 5'd2, 5'd31, 1'b1);
    stepCycle("z.load");
    issue(5'd31, 5'd0, 5'd8, 1'b0);
    stepCycle("z.use");
    check("z.use_valid", 64'(ex_valid), 64'd1);

    // Stall with refresh of held rs2=9.
    rf[9] = 64'h99;
    issue(5'd1, 5'd9, 5'd10, 1'b0);
    stepCycle("st.load");
    idle();
    stall = 1;
    stepCycle("st.c1");
    wb_reg_write = 1; wb_rd = 5'd9; wb_data = 64'hBEEF;
    stepCycle("st.c2");
    wb_reg_write = 0;
    stepCycle("st.c3");
    check("st.opb_const", ex_op_b, 64'hBEEF);
    check("st.rs2_const", 64'(ex_rs2), 64'd9);

    // Flush wins over stall.
    idle();
    issue(5'd2, 5'd3, 5'd4, 1'b1);
    stepCycle("fs.load");
    stall = 1; flush = 1;
    stepCycle("fs.both");
    check("fs.valid_const", 64'(ex_valid), 64'd0);
    check("fs.mr_const", 64'(ex_mem_read), 64'd0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      stall        = ($urandom_range(0, 4) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      id_valid     = ($urandom_range(0, 5) != 0);
      id_rs1       = randIdx();
      id_rs2       = randIdx();
      id_rd        = randIdx();
      id_reg_write = 1'($urandom);
      id_mem_read  = ($urandom_range(0, 2) == 0);
      id_imm       = {$urandom, $urandom};
      wb_reg_write = 1'($urandom);
      wb_rd        = randIdx();
      wb_data      = {$urandom, $urandom};
      stepCycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 64-bit LEGv8 pipelined datapath.
- Sits directly downstream of the 32x64 register file.
- Captures the two register-file read ports, immediate and control bits each clock.
- Applies a write-back bypass for the same-cycle write/read case. Register writes land at the clock edge and reads are combinational, so without the bypass a same-cycle read returns the stale value.
- Detects load-use hazards and inserts a bubble, or holds or flushes on request.

Parameters:
- DATA_W, 64, datapath width
- REG_W, 5, register index width; index 2**REG_W-1 (X31) is hard-wired zero

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- stall  input  1  hold all EX-side state (downstream memory stall)
- flush  input  1  squash: next EX slot is a bubble (branch taken)
- id_valid  input  1  ID slot holds a real instruction
- id_rs1, id_rs2, id_rd  input  REG_W  source/dest indices
- id_reg_write, id_mem_read  input  1  control bits
- id_imm  input  DATA_W  sign-extended immediate
- id_read_data1, id_read_data2  input  DATA_W  register-file read ports
- wb_reg_write  input  1  WB-stage write enable (same signal driving register file)
- wb_rd  input  REG_W  WB destination
- wb_data  input  DATA_W  WB write data
- ex_valid  output  1  EX slot valid
- ex_rs1, ex_rs2, ex_rd  output  REG_W  registered indices (for EX forwarding)
- ex_reg_write, ex_mem_read  output  1  registered control, forced 0 when ex_valid=0
- ex_op_a, ex_op_b, ex_imm  output  DATA_W  registered operands
- load_use_hazard  output  1  combinational; ID must hold its instruction this cycle

Behaviour:
- Reset (async, rst=1): every output register is 0, including ex_valid, all indices, control bits and data. load_use_hazard is 0 because ex_valid=0.
- Bypass, combinational on ID side:
  - byp_a = wb_data if wb_reg_write && wb_rd==id_rs1 && id_rs1!=31, else id_read_data1.
  - byp_b is the same with id_rs2 and id_read_data2.
  - rs==31 never bypasses; data passes through as 0 from the register file.
- Hazard: load_use_hazard = ex_valid && ex_mem_read && ex_rd!=31 && id_valid && (ex_rd==id_rs1 || ex_rd==id_rs2).
- Update at each posedge, priority order:
  1. flush: ex_valid, ex_reg_write, ex_mem_read <= 0. Data and index fields are don't-care; they are zeroed.
  2. stall: all fields hold. Exception: if wb_reg_write && wb_rd!=31, then wb_rd==ex_rs1 loads ex_op_a<=wb_data and wb_rd==ex_rs2 loads ex_op_b<=wb_data. This keeps the held operands fresh.
  3. load_use_hazard: bubble, same as flush. Upstream holds ID, so the instruction re-enters next cycle with the load result available via bypass or forwarding.
  4. otherwise: load all ID fields. ex_valid<=id_valid. Control bits are gated by id_valid. Operands take byp_a/byp_b.
- flush and stall together: flush wins. Reset mid-stall: reset wins immediately, asynchronously.
- Latency: exactly 1 cycle ID->EX when not stalled/hazarded. A hazard costs exactly 1 bubble.
- No arithmetic; widths pass through unchanged.

Test Plan:
- Reset: assert rst mid-cycle with ex_valid=1 -> all outputs 0 before next edge. Deassert, load id_rs1=3, data1=0x11 -> next cycle ex_op_a=0x11, ex_valid=1.
- WB bypass: id_rs1=5, id_read_data1=0xAAAA, wb_reg_write=1, wb_rd=5, wb_data=0x1234 -> ex_op_a=0x1234. Same with wb_rd=31, id_rs1=31, data1=0 -> ex_op_a=0.
- Load-use: EX holds a load with ex_rd=7; ID id_rs2=7 -> load_use_hazard=1, next cycle ex_valid=0 and ex_reg_write=0. Following cycle the ID instruction loads, ex_valid=1.
- Hazard on X31: EX load with ex_rd=31, id_rs1=31 -> load_use_hazard=0, no bubble.
- Stall with refresh: ex_rs2=9 held, stall=1 for 3 cycles, wb write rd=9 data=0xBEEF in cycle 2 -> ex_op_b=0xBEEF from cycle 3. All other fields unchanged.
- Flush vs stall: flush=1, stall=1 with valid EX -> next cycle ex_valid=0, ex_mem_read=0.
